port_uart_tx: RTL and testbench
===============================

// Module: port_uart_tx
// PURPOSE
//  Downstream consumer of one jimmy CPU output port. Captures each byte the CPU
//  writes (OUTPUT instruction: data on out_port_N, one-cycle active-low out_strobe[N]).
//  Buffers bytes in a small FIFO and serializes them as 8N1 UART frames on tx.
//  A status byte is returned for wiring into a CPU in_port for software polling.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; must be >= 2
//  FIFO_AW       2   FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk              in   1  system clock; all logic on posedge
//  reset            in   1  reset, synchronous, active-low
//  port_data        in   8  byte from CPU out_port_N
//  port_strobe_n    in   1  CPU out_strobe[N]; low = write port_data this cycle
//  status_strobe_n  in   1  CPU in_strobe[M] of the status port; low = status read
//  status           out  8  {5'b0, overflow, fifo_full, busy}
//  tx               out  1  serial line, idle high
// BEHAVIOUR
//  Reset (reset==0 at posedge): tx=1, status=8'h00, FIFO empty (rd/wr ptr=0,
//   count=0), FSM=IDLE, baud counter=0, bit index=0, overflow=0. Applies mid-frame:
//   frame is abandoned, tx high after that edge, FIFO contents discarded.
//  Write: every posedge with port_strobe_n==0 is one write; consecutive low cycles
//   = consecutive writes. Not full -> push port_data. Full -> byte dropped,
//   overflow sets (sticky).
//  Simultaneous push+pop while full: both happen, count unchanged, no overflow.
//  Pop occurs only when count!=0; no FIFO bypass.
//  FIFO: circular, pointers wrap modulo 2**FIFO_AW; count width FIFO_AW+1.
//  FSM (one-hot or binary, registered tx):
//   IDLE : tx=1. If count!=0: pop head into shift reg, baud cnt=0 -> START.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit index=0.
//   DATA : tx=shift[0] (LSB first), CLKS_PER_BIT cycles/bit; shift right each bit;
//          after bit 7 -> STOP.
//   STOP : tx=1 for CLKS_PER_BIT cycles. At end: count!=0 -> pop, START
//          (back-to-back, no idle gap); else -> IDLE.
//  Frame = exactly 10*CLKS_PER_BIT cycles of tx.
//  Latency: write sampled at edge t into empty FIFO in IDLE -> pop at edge t+1,
//   tx low from edge t+2 (start bit observable 2 cycles after strobe edge).
//  Status (registered, updated every cycle):
//   busy      = (FSM!=IDLE) | (count!=0)
//   fifo_full = count==2**FIFO_AW
//   overflow  = sticky; cleared at posedge with status_strobe_n==0; if a drop and
//               a clear coincide, set wins.
//   The CPU reads status the cycle its in_strobe is low; a clear takes effect
//   for the next read.
//  No flow control back to CPU; software polls fifo_full before OUTPUT.
// TESTING (CLKS_PER_BIT=4, FIFO_AW=2)
//  1 Reset: hold reset=0 3 cycles -> tx=1, status=8'h00; release, idle 20 cycles
//    -> tx stays 1.
//  2 Single byte 8'hA5, one strobe cycle -> tx low 2 cycles later for 4 cycles,
//    then 1,0,1,0,0,1,0,1 (4 cycles each), stop 1 for 4; busy falls after 40 cycles.
//  3 Burst 5 bytes 8'h01..8'h05 on consecutive cycles -> first popped, next 4 fill
//    FIFO (fifo_full=1), no overflow; 5 frames back-to-back, 200 tx cycles, no gap.
//  4 Overflow: 6 writes back-to-back -> 6th (8'h06) dropped, status[2]=1; strobe
//    status_strobe_n -> status[2]=0 next cycle; drop+clear same cycle -> stays 1.
//  5 Push while full coinciding with STOP-end pop -> byte accepted, count stays 4,
//    overflow 0, all bytes emitted in order.
//  6 Reset asserted mid-DATA of 8'hFF with 3 bytes queued -> tx=1 next edge,
//    status=8'h00, no further frames after release.

Source files
------------

// File: rtl/port_uart_tx.sv
// Output-port consumer: captures CPU port writes into a small FIFO and
// serializes them as 8N1 UART frames, with a pollable status byte.
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_data,
    input  logic       port_strobe_n,
    input  logic       status_strobe_n,
    output logic [7:0] status,
    output logic       tx
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]    BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   count, count_next;
    state_t             state, state_next;
    logic [CW-1:0]      baud_cnt, baud_next;
    logic [2:0]         bit_idx, bit_next;
    logic [7:0]         shift, shift_next;
    logic               pop, push, drop, fifo_full, baud_end;
    logic               overflow, overflow_next, busy_next;

    assign fifo_full = (count == FULL_CNT);
    assign baud_end  = (baud_cnt == BAUD_MAX);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    // Queued byte starts its start bit straight after the stop bit.
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A write into a full FIFO still lands if a pop frees a slot this cycle.
    assign push = !port_strobe_n && (!fifo_full || pop);
    assign drop = !port_strobe_n && fifo_full && !pop;

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        if (drop) begin
            overflow_next = 1'b1;
        end else if (!status_strobe_n) begin
            overflow_next = 1'b0;
        end else begin
            overflow_next = overflow;
        end
        busy_next = (state_next != IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= port_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
            status   <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            count    <= count_next;
            overflow <= overflow_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // tx follows the registered state, one cycle behind it.
            tx     <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
            status <= {5'b0, overflow_next, count_next == FULL_CNT, busy_next};
        end
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: vector table, directed frame sequences and random
// traffic checked against a timeline-based reference model.
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] port_data = '0;
    logic       port_strobe_n = 1'b1;
    logic       status_strobe_n = 1'b1;
    logic [7:0] status;
    logic       tx;

    port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .port_data(port_data),
        .port_strobe_n(port_strobe_n), .status_strobe_n(status_strobe_n),
        .status(status), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue plus the edge at which the current frame began.
    logic [7:0] m_q [$];
    logic [7:0] m_byte = '0;
    logic       m_have = 1'b0;
    logic       m_ovf  = 1'b0;
    int         m_fs   = 0;
    int         ecount = 0;

    task automatic model_edge(input logic r, input logic sn, input logic [7:0] d, input logic ssn);
        logic free, pop, full, drop;
        if (!r) begin
            m_q.delete();
            m_have = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        free = !m_have || (ecount >= m_fs + 10 * CPB);
        pop  = free && (m_q.size() != 0);
        full = (m_q.size() == DEPTH);
        if (pop) begin
            m_byte = m_q.pop_front();
            m_have = 1'b1;
            m_fs   = ecount;
        end
        drop = 1'b0;
        if (!sn) begin
            if (full && !pop) drop = 1'b1;
            else m_q.push_back(d);
        end
        if (drop) m_ovf = 1'b1;
        else if (!ssn) m_ovf = 1'b0;
    endtask

    function automatic logic model_tx();
        int ph;
        if (!m_have || ecount < m_fs + 1) return 1'b1;
        ph = ecount - m_fs - 1;
        if (ph >= 9 * CPB) return 1'b1;
        if (ph < CPB) return 1'b0;
        return m_byte[ph / CPB - 1];
    endfunction

    function automatic logic model_busy();
        return (m_have && ecount < m_fs + 10 * CPB) || (m_q.size() != 0);
    endfunction

    function automatic logic [7:0] model_status();
        return {5'b0, m_ovf, m_q.size() == DEPTH, model_busy()};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, ecount, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic sn, input logic [7:0] d, input logic ssn);
        reset = r;
        port_strobe_n = sn;
        port_data = d;
        status_strobe_n = ssn;
        @(posedge clk);
        ecount++;
        model_edge(r, sn, d, ssn);
        #1;
        check("tx", {7'b0, tx}, {7'b0, model_tx()});
        check("status", status, model_status());
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (model_busy() && n < 400) begin
            idle();
            n++;
        end
        if (model_busy()) begin
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       sn;
        logic [7:0] d;
        logic       ssn;
        logic       exp_tx;
        logic [7:0] exp_st;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic sn, input logic [7:0] d,
                                input logic ssn, input logic et, input logic [7:0] es);
        vec_t v;
        v.rst = r; v.sn = sn; v.d = d; v.ssn = ssn; v.exp_tx = et; v.exp_st = es;
        return v;
    endfunction

    initial begin
        int first_low, busy_len, n;

        // Reset hold, idle line, then overflow set/clear/coincidence and a mid-frame reset.
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h00));
        for (int i = 0; i < 20; i++) tbl.push_back(mk(1, 1, 8'h00, 1, 1, 8'h00));
        tbl.push_back(mk(1, 0, 8'h01, 1, 1, 8'h01));
        tbl.push_back(mk(1, 0, 8'h02, 1, 1, 8'h01));
        tbl.push_back(mk(1, 0, 8'h03, 1, 0, 8'h01));
        tbl.push_back(mk(1, 0, 8'h04, 1, 0, 8'h01));
        tbl.push_back(mk(1, 0, 8'h05, 1, 0, 8'h03));
        tbl.push_back(mk(1, 0, 8'h06, 1, 0, 8'h07));
        tbl.push_back(mk(1, 1, 8'h00, 1, 1, 8'h07));
        tbl.push_back(mk(1, 1, 8'h00, 0, 1, 8'h03));
        tbl.push_back(mk(1, 1, 8'h00, 1, 1, 8'h03));
        tbl.push_back(mk(1, 0, 8'h07, 0, 1, 8'h07));
        tbl.push_back(mk(1, 1, 8'h00, 1, 0, 8'h07));
        tbl.push_back(mk(1, 1, 8'h00, 0, 0, 8'h03));
        tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 8'h00, 1, 1, 8'h00));

        #1;
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sn, tbl[i].d, tbl[i].ssn);
            check("vec_tx", {7'b0, tx}, {7'b0, tbl[i].exp_tx});
            check("vec_status", status, tbl[i].exp_st);
        end
        for (int i = 0; i < 3; i++) idle();

        // Single byte: start-bit latency and busy duration.
        step(1'b1, 1'b0, 8'hA5, 1'b1);
        first_low = -1;
        busy_len  = 0;
        n = 0;
        while (status[0] && n < 100) begin
            idle();
            n++;
            if (first_low < 0 && tx == 1'b0) first_low = n;
            if (status[0]) busy_len++;
        end
        check("start_latency", 8'(first_low), 8'd2);
        check("busy_len", 8'(busy_len), 8'd40);

        // Burst of five fills the FIFO without overflow, frames back-to-back.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
        check("burst_full", status, 8'h03);
        drain();

        // Push while full on the same edge as the stop-bit-end pop.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b1);
        n = 0;
        while (!(m_have && ecount + 1 == m_fs + 10 * CPB) && n < 100) begin
            idle();
            n++;
        end
        step(1'b1, 1'b0, 8'hC3, 1'b1);
        check("push_on_pop", status, 8'h03);
        drain();

        // Reset in the middle of a frame with bytes queued.
        step(1'b1, 1'b0, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        for (int i = 0; i < 8; i++) idle();
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("midreset_tx", {7'b0, tx}, 8'h01);
        check("midreset_status", status, 8'h00);
        for (int i = 0; i < 60; i++) idle();

        // Random traffic, status reads and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 24) != 0),
                 8'($urandom),
                 ($urandom_range(0, 15) != 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
